// File: rtl/fifo_drain.sv
// fifo_drain: read-side controller for the DEPTH-deep shift-register FIFO.
// A start pulse drains the FIFO into a local register file. Each shift
// back-fills the FIFO with zero. The block also keeps a wrap-around signed
// sum and a capture count. MMIO reads the captured words by index.
//
// Ports:
//   clk, rst    rising-edge clock, async active-high reset
//   start       begin a drain (sampled only in IDLE)
//   hold        stall: no shift, no capture
//   fifo_q      oldest FIFO word
//   fifo_en     FIFO shift enable
//   fifo_d      FIFO back-fill data (always 0)
//   busy        high while capturing
//   done        one-cycle completion pulse
//   count       words captured in current/last run
//   sum         wrap-around signed sum of captured words
//   rd_addr     register-file read index
//   rd_data     combinational read of the register file
module fifo_drain #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       hold,
  input  logic signed [WIDTH-1:0]    fifo_q,
  output logic                       fifo_en,
  output logic signed [WIDTH-1:0]    fifo_d,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     count,
  output logic signed [WIDTH-1:0]    sum,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic signed [WIDTH-1:0]    rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t                  state;
  logic [AW-1:0]           idx;
  logic signed [WIDTH-1:0] mem [DEPTH];

  assign busy    = (state == CAPTURE);
  assign fifo_en = busy & ~hold;
  assign done    = (state == DONE);
  assign fifo_d  = '0;
  // Old value is returned until the capturing edge writes the entry.
  assign rd_data = mem[rd_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      count <= '0;
      sum   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= CAPTURE;
          idx   <= '0;
          count <= '0;
          sum   <= '0;
        end
        CAPTURE: if (fifo_en) begin
          mem[idx] <= fifo_q;
          sum      <= sum + fifo_q;
          count    <= count + CW'(1);
          // idx tracks count within a run, so the last slot marks the final
          // capture; idx parks there instead of wrapping.
          if (idx == AW'(DEPTH - 1)) state <= DONE;
          else                       idx   <= idx + AW'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
